cpu_step_sequencer: RTL and testbench

Multi-cycle sequencer for the single-port CPU datapath.
- Steps each instruction through FETCH, DECODE, EXEC, MEM and WB.
- Gates the write enables produced by the instruction decoder, so register and memory writes happen only in their own step.
- Arbitrates the one memory port between instruction fetch and data load/store, with a ready handshake and a timeout.

---
 rtl/cpu_pkg.sv | 62 ++++++
 rtl/op_class_decode.sv | 32 +++
 rtl/cpu_step_sequencer.sv | 203 ++++++++++++++++++++
 tb/tb_cpu_step_sequencer.sv | 392 +++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/cpu_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : cpu_pkg
//  Description : Shared definitions for the multi-cycle CPU sequencer:
//                opcode/subopcode constants, state and class encodings,
//                PC source select codes.
//  Revision    : 1.0  initial release
// ============================================================================
package cpu_pkg;

    localparam int C_OPCODE_W = 6;
    localparam int C_SUBOP_W  = 5;

    // Opcodes decoded by the sequencer
    localparam logic [C_OPCODE_W-1:0] C_OP_ADD    = 6'b100000;
    localparam logic [C_OPCODE_W-1:0] C_OP_ALU_28 = 6'b101000;
    localparam logic [C_OPCODE_W-1:0] C_OP_ALU_2C = 6'b101100;
    localparam logic [C_OPCODE_W-1:0] C_OP_ALU_2B = 6'b101011;
    localparam logic [C_OPCODE_W-1:0] C_OP_SUB    = 6'b100010;
    localparam logic [C_OPCODE_W-1:0] C_OP_LW     = 6'b000010;
    localparam logic [C_OPCODE_W-1:0] C_OP_LSW    = 6'b011100;
    localparam logic [C_OPCODE_W-1:0] C_OP_SWI    = 6'b001010;
    localparam logic [C_OPCODE_W-1:0] C_OP_BEQ    = 6'b100110;
    localparam logic [C_OPCODE_W-1:0] C_OP_J      = 6'b100100;

    // Subopcode of the shared load/store opcode that selects a load
    localparam logic [C_SUBOP_W-1:0]  C_SUB_LSW_LOAD = 5'b00010;

    // Sequencer states (value is visible on the debug port)
    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_FETCH  = 3'd1,
        S_DECODE = 3'd2,
        S_EXEC   = 3'd3,
        S_MEM    = 3'd4,
        S_WB     = 3'd5,
        S_HALT   = 3'd6,
        S_ERR    = 3'd7
    } state_t;

    // Instruction classes
    typedef enum logic [2:0] {
        CLS_ALU   = 3'd0,
        CLS_LOAD  = 3'd1,
        CLS_STORE = 3'd2,
        CLS_BR    = 3'd3,
        CLS_JMP   = 3'd4,
        CLS_ILL   = 3'd5
    } op_class_t;

    // PC source select codes
    localparam logic [1:0] C_PC_SEL_PC4 = 2'd0;
    localparam logic [1:0] C_PC_SEL_BR  = 2'd1;
    localparam logic [1:0] C_PC_SEL_JMP = 2'd2;

    // States that own the memory port and are subject to the wait timeout
    function automatic logic is_mem_state(input state_t s);
        return (s == S_FETCH) || (s == S_MEM);
    endfunction

endpackage
`default_nettype wire

// File: rtl/op_class_decode.sv
`default_nettype none
// ============================================================================
//  Module      : op_class_decode
//  Description : Combinational opcode/subopcode to instruction-class map.
//                Shared by the sequencer, hazard and debug logic.
//  Revision    : 1.0  initial release
// ============================================================================
module op_class_decode
    import cpu_pkg::*;
(
    input  logic [C_OPCODE_W-1:0] opcode,
    input  logic [C_SUBOP_W-1:0]  subopcode,
    output op_class_t             op_class
);

    // Classify the instruction; anything not listed is illegal
    always_comb begin
        op_class = CLS_ILL;
        case (opcode)
            C_OP_ADD, C_OP_ALU_28, C_OP_ALU_2C,
            C_OP_ALU_2B, C_OP_SUB:  op_class = CLS_ALU;
            C_OP_LW:                op_class = CLS_LOAD;
            C_OP_LSW:               op_class = (subopcode == C_SUB_LSW_LOAD) ? CLS_LOAD : CLS_STORE;
            C_OP_SWI:               op_class = CLS_STORE;
            C_OP_BEQ:               op_class = CLS_BR;
            C_OP_J:                 op_class = CLS_JMP;
            default:                op_class = CLS_ILL;
        endcase
    end

endmodule
`default_nettype wire

// File: rtl/cpu_step_sequencer.sv
`default_nettype none
// ============================================================================
//  Module      : cpu_step_sequencer
//  Description : Multi-cycle FETCH/DECODE/EXEC/MEM/WB sequencer for the
//                single-port CPU datapath. Gates decoder write enables to
//                their own step and arbitrates the shared memory port with a
//                ready handshake and wait timeout.
//                Optional macro PERF_CNT_EN adds cycle_cnt / instr_cnt.
//  Revision    : 1.0  initial release
// ============================================================================
module cpu_step_sequencer
    import cpu_pkg::*;
#(
    parameter int MEM_TIMEOUT = 15
`ifdef PERF_CNT_EN
    ,
    parameter int CNT_W = 32
`endif
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic                  halt_req,
    input  logic [C_OPCODE_W-1:0] opcode,
    input  logic [C_SUBOP_W-1:0]  subopcode,
    input  logic                  branch_taken,
    input  logic                  mem_ready,
    output logic                  mem_req,
    output logic                  mem_we,
    output logic                  mem_addr_sel,
    output logic                  ir_we,
    output logic                  pc_we,
    output logic [1:0]            pc_sel,
    output logic                  reg_we,
    output logic                  retire,
    output logic                  illegal,
    output logic                  err,
`ifdef PERF_CNT_EN
    output logic [CNT_W-1:0]      cycle_cnt,
    output logic [CNT_W-1:0]      instr_cnt,
`endif
    output logic [2:0]            state
);

    // Last wait count tolerated; one more idle cycle trips the timeout
    localparam logic [7:0] C_TIMEOUT_LAST = 8'(MEM_TIMEOUT - 1);

    state_t    state_q, state_d;
    op_class_t cls_q, cls_d;
    logic [7:0] wait_q, wait_d;
    logic      err_q, err_d;
    op_class_t w_dec_cls;
    logic      w_timeout_hit;

    op_class_decode u_op_class_decode (
        .opcode    (opcode),
        .subopcode (subopcode),
        .op_class  (w_dec_cls)
    );

    assign w_timeout_hit = (wait_q == C_TIMEOUT_LAST) && !mem_ready;

    // Next-state and step outputs; DECODE uses the live decode since the
    // class register only captures it at the end of that step
    always_comb begin
        state_d      = state_q;
        cls_d        = cls_q;
        err_d        = err_q;
        mem_req      = 1'b0;
        mem_we       = 1'b0;
        mem_addr_sel = 1'b0;
        ir_we        = 1'b0;
        pc_we        = 1'b0;
        pc_sel       = C_PC_SEL_PC4;
        reg_we       = 1'b0;
        retire       = 1'b0;
        illegal      = 1'b0;
        case (state_q)
            S_IDLE, S_HALT: begin
                if (start) state_d = S_FETCH;
            end
            S_FETCH: begin
                mem_req = 1'b1;
                if (mem_ready) begin
                    ir_we   = 1'b1;
                    state_d = S_DECODE;
                end else if (w_timeout_hit) begin
                    state_d = S_ERR;
                    err_d   = 1'b1;
                end
            end
            S_DECODE: begin
                cls_d = w_dec_cls;
                if (w_dec_cls == CLS_ILL) begin
                    illegal = 1'b1;
                    pc_we   = 1'b1;
                    state_d = S_FETCH;
                end else begin
                    state_d = S_EXEC;
                end
            end
            S_EXEC: begin
                case (cls_q)
                    CLS_ALU:              state_d = S_WB;
                    CLS_LOAD, CLS_STORE:  state_d = S_MEM;
                    CLS_BR: begin
                        pc_we  = 1'b1;
                        pc_sel = branch_taken ? C_PC_SEL_BR : C_PC_SEL_PC4;
                        retire = 1'b1;
                    end
                    CLS_JMP: begin
                        pc_we  = 1'b1;
                        pc_sel = C_PC_SEL_JMP;
                        retire = 1'b1;
                    end
                    default:              state_d = S_FETCH;
                endcase
            end
            S_MEM: begin
                mem_req      = 1'b1;
                mem_addr_sel = 1'b1;
                mem_we       = (cls_q == CLS_STORE);
                if (mem_ready) begin
                    if (cls_q == CLS_STORE) begin
                        pc_we  = 1'b1;
                        retire = 1'b1;
                    end else begin
                        state_d = S_WB;
                    end
                end else if (w_timeout_hit) begin
                    state_d = S_ERR;
                    err_d   = 1'b1;
                end
            end
            S_WB: begin
                reg_we = 1'b1;
                pc_we  = 1'b1;
                retire = 1'b1;
            end
            default: begin
                state_d = S_ERR;
            end
        endcase
        // Every retiring step chooses between halting and the next fetch
        if (retire) state_d = halt_req ? S_HALT : S_FETCH;
    end

    // Wait counter: consecutive un-ready cycles within one memory step
    always_comb begin
        wait_d = '0;
        if (is_mem_state(state_q) && !mem_ready && (state_d == state_q))
            wait_d = wait_q + 8'd1;
    end

    // State, class, wait counter and sticky error registers
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= S_IDLE;
            cls_q   <= CLS_ALU;
            wait_q  <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cls_q   <= cls_d;
            wait_q  <= wait_d;
            err_q   <= err_d;
        end
    end

    assign err   = err_q;
    assign state = state_q;

`ifdef PERF_CNT_EN
    logic [CNT_W-1:0] cycle_cnt_q, cycle_cnt_d;
    logic [CNT_W-1:0] instr_cnt_q, instr_cnt_d;

    // Busy-cycle and retired-instruction counters, wrapping at overflow
    always_comb begin
        cycle_cnt_d = cycle_cnt_q;
        instr_cnt_d = instr_cnt_q;
        if ((state_q != S_IDLE) && (state_q != S_HALT) && (state_q != S_ERR))
            cycle_cnt_d = cycle_cnt_q + CNT_W'(1);
        if (retire)
            instr_cnt_d = instr_cnt_q + CNT_W'(1);
    end

    // Counter registers
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cycle_cnt_q <= '0;
            instr_cnt_q <= '0;
        end else begin
            cycle_cnt_q <= cycle_cnt_d;
            instr_cnt_q <= instr_cnt_d;
        end
    end

    assign cycle_cnt = cycle_cnt_q;
    assign instr_cnt = instr_cnt_q;
`endif

endmodule
`default_nettype wire

// File: tb/tb_cpu_step_sequencer.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module      : tb_cpu_step_sequencer
//  Description : Self-checking bench for cpu_step_sequencer. A per-instruction
//                cycle plan (stimulus + expected outputs) is derived from the
//                instruction class and the memory wait counts.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_cpu_step_sequencer;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst, start, halt_req, branch_taken, mem_ready;
    logic [5:0] opcode;
    logic [4:0] subopcode;
    logic       mem_req, mem_we, mem_addr_sel, ir_we, pc_we, reg_we, retire, illegal, err;
    logic [1:0] pc_sel;
    logic [2:0] state;
`ifdef PERF_CNT_EN
    logic [31:0] cycle_cnt, instr_cnt;
`endif

    cpu_step_sequencer dut (
        .clk          (clk),
        .rst          (rst),
        .start        (start),
        .halt_req     (halt_req),
        .opcode       (opcode),
        .subopcode    (subopcode),
        .branch_taken (branch_taken),
        .mem_ready    (mem_ready),
        .mem_req      (mem_req),
        .mem_we       (mem_we),
        .mem_addr_sel (mem_addr_sel),
        .ir_we        (ir_we),
        .pc_we        (pc_we),
        .pc_sel       (pc_sel),
        .reg_we       (reg_we),
        .retire       (retire),
        .illegal      (illegal),
        .err          (err),
`ifdef PERF_CNT_EN
        .cycle_cnt    (cycle_cnt),
        .instr_cnt    (instr_cnt),
`endif
        .state        (state)
    );

    logic [10:0] outs_w;
    assign outs_w = {mem_req, mem_we, mem_addr_sel, ir_we, pc_we, pc_sel,
                     reg_we, retire, illegal, err};

    // Output bit masks within outs_w
    localparam logic [10:0] O_REQ  = 11'b100_0000_0000;
    localparam logic [10:0] O_WE   = 11'b010_0000_0000;
    localparam logic [10:0] O_ASEL = 11'b001_0000_0000;
    localparam logic [10:0] O_IRWE = 11'b000_1000_0000;
    localparam logic [10:0] O_PCWE = 11'b000_0100_0000;
    localparam logic [10:0] O_BRT  = 11'b000_0001_0000;
    localparam logic [10:0] O_JMPT = 11'b000_0010_0000;
    localparam logic [10:0] O_RWE  = 11'b000_0000_1000;
    localparam logic [10:0] O_RET  = 11'b000_0000_0100;
    localparam logic [10:0] O_ILL  = 11'b000_0000_0010;
    localparam logic [10:0] O_ERR  = 11'b000_0000_0001;
    localparam logic [10:0] O_NONE = 11'b000_0000_0000;

    localparam logic [2:0] T_IDLE = 3'd0, T_FETCH = 3'd1, T_DECODE = 3'd2, T_EXEC = 3'd3,
                           T_MEM = 3'd4, T_WB = 3'd5, T_HALT = 3'd6, T_ERR = 3'd7;

    localparam int K_ALU = 0, K_LOAD = 1, K_STORE = 2, K_BR = 3, K_JMP = 4, K_ILL = 5;

    logic [5:0] alu_ops [5] = '{6'b100000, 6'b101000, 6'b101100, 6'b101011, 6'b100010};
    logic [5:0] op_pool [10] = '{6'b100000, 6'b101000, 6'b101100, 6'b101011, 6'b100010,
                                 6'b000010, 6'b011100, 6'b001010, 6'b100110, 6'b100100};

    typedef struct {
        logic [5:0]  op;
        logic [4:0]  sub;
        logic        st;
        logic        mr;
        logic        bt;
        logic        hr;
        logic [2:0]  state;
        logic [10:0] outs;
    } cyc_t;

    cyc_t plan[$];
    int   errors = 0;
    int   checks = 0;

    function automatic logic rb();
        return 1'($urandom_range(0, 1));
    endfunction

    // Instruction class straight from the opcode tables
    function automatic int classify(input logic [5:0] op, input logic [4:0] sub);
        foreach (alu_ops[i]) if (op == alu_ops[i]) return K_ALU;
        if (op == 6'b000010) return K_LOAD;
        if (op == 6'b011100) return (sub == 5'b00010) ? K_LOAD : K_STORE;
        if (op == 6'b001010) return K_STORE;
        if (op == 6'b100110) return K_BR;
        if (op == 6'b100100) return K_JMP;
        return K_ILL;
    endfunction

    task automatic add(input logic [5:0] op, input logic [4:0] sub, input logic st,
                       input logic mr, input logic bt, input logic hr,
                       input logic [2:0] s, input logic [10:0] o);
        cyc_t c;
        c.op = op; c.sub = sub; c.st = st; c.mr = mr; c.bt = bt; c.hr = hr;
        c.state = s; c.outs = o;
        plan.push_back(c);
    endtask

    // Expected cycle sequence of one instruction starting in FETCH.
    // fw/mw = un-ready cycles before the fetch / data access completes.
    task automatic plan_instr(input logic [5:0] op, input logic [4:0] sub, input int fw,
                              input int mw, input logic bt, input logic hr);
        int k;
        k = classify(op, sub);
        for (int i = 0; i < fw; i++) add(op, sub, rb(), 1'b0, rb(), rb(), T_FETCH, O_REQ);
        add(op, sub, rb(), 1'b1, rb(), rb(), T_FETCH, O_REQ | O_IRWE);
        if (k == K_ILL) begin
            add(op, sub, rb(), rb(), rb(), rb(), T_DECODE, O_ILL | O_PCWE);
            return;
        end
        add(op, sub, rb(), rb(), rb(), rb(), T_DECODE, O_NONE);
        if (k == K_BR) begin
            add(op, sub, rb(), rb(), bt, hr, T_EXEC, O_PCWE | O_RET | (bt ? O_BRT : O_NONE));
        end else if (k == K_JMP) begin
            add(op, sub, rb(), rb(), bt, hr, T_EXEC, O_PCWE | O_RET | O_JMPT);
        end else if (k == K_ALU) begin
            add(op, sub, rb(), rb(), rb(), rb(), T_EXEC, O_NONE);
            add(op, sub, rb(), rb(), rb(), hr, T_WB, O_RWE | O_PCWE | O_RET);
        end else begin
            add(op, sub, rb(), rb(), rb(), rb(), T_EXEC, O_NONE);
            for (int i = 0; i < mw; i++)
                add(op, sub, rb(), 1'b0, rb(), rb(), T_MEM,
                    O_REQ | O_ASEL | ((k == K_STORE) ? O_WE : O_NONE));
            if (k == K_STORE) begin
                add(op, sub, rb(), 1'b1, rb(), hr, T_MEM, O_REQ | O_ASEL | O_WE | O_PCWE | O_RET);
            end else begin
                add(op, sub, rb(), 1'b1, rb(), rb(), T_MEM, O_REQ | O_ASEL);
                add(op, sub, rb(), rb(), rb(), hr, T_WB, O_RWE | O_PCWE | O_RET);
            end
        end
        if (hr) begin
            add(op, sub, 1'b0, rb(), rb(), rb(), T_HALT, O_NONE);
            add(op, sub, 1'b1, rb(), rb(), rb(), T_HALT, O_NONE);
        end
    endtask

    task automatic apply(input cyc_t c);
        @(posedge clk); #1;
        opcode = c.op; subopcode = c.sub; start = c.st;
        mem_ready = c.mr; branch_taken = c.bt; halt_req = c.hr;
        #4;
    endtask

    task automatic do_reset();
        @(posedge clk); #1;
        rst = 1'b0; start = 1'b0; halt_req = 1'b0; mem_ready = 1'b0; branch_taken = 1'b0;
        @(posedge clk); @(posedge clk); #1;
        rst = 1'b1;
    endtask

    task automatic test_reset();
        rst = 1'b0; start = 1'b0; halt_req = 1'b0; mem_ready = 1'b0; branch_taken = 1'b0;
        opcode = 6'b100000; subopcode = 5'b00000;
        for (int i = 0; i < 3; i++) begin
            @(posedge clk); #1;
            start = 1'b1; mem_ready = rb(); halt_req = rb(); branch_taken = rb();
            #4;
            checks++;
            if ({state, outs_w} !== {T_IDLE, O_NONE}) begin
                errors++;
                $display("FAIL reset[%0d]: state=%0d outs=%b, want state=0 outs=0", i, state, outs_w);
            end
        end
        @(posedge clk); #1;
        rst = 1'b1; start = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(posedge clk); #1;
            mem_ready = rb(); halt_req = rb();
            #4;
            checks++;
            if ({state, outs_w} !== {T_IDLE, O_NONE}) begin
                errors++;
                $display("FAIL idle[%0d]: state=%0d outs=%b, want state=0 outs=0", i, state, outs_w);
            end
        end
    endtask

    task automatic test_alu();
        do_reset();
        add(6'b100000, 5'd0, 1'b1, rb(), rb(), rb(), T_IDLE, O_NONE);
        plan_instr(6'b100000, 5'd0, 0, 0, 1'b0, 1'b0);
        for (int i = 0; i < 5; i++)
            plan_instr(alu_ops[i], 5'($urandom), $urandom_range(0, 3), 0, rb(), 1'b0);
        foreach (plan[i]) begin
            apply(plan[i]);
            checks++;
            if ({state, outs_w} !== {plan[i].state, plan[i].outs}) begin
                errors++;
                $display("FAIL alu[%0d]: state=%0d outs=%b, want state=%0d outs=%b",
                         i, state, outs_w, plan[i].state, plan[i].outs);
            end
        end
        plan.delete();
    endtask

    task automatic test_load_store();
        logic [4:0] s;
        do_reset();
        add(6'b011100, 5'b00010, 1'b1, rb(), rb(), rb(), T_IDLE, O_NONE);
        plan_instr(6'b011100, 5'b00010, 0, 3, 1'b0, 1'b0);
        plan_instr(6'b000010, 5'($urandom), $urandom_range(0, 3), $urandom_range(0, 3), 1'b0, 1'b0);
        plan_instr(6'b001010, 5'($urandom), 0, 0, 1'b0, 1'b0);
        s = 5'($urandom);
        if (s == 5'b00010) s = 5'b00011;
        plan_instr(6'b011100, s, 1, 2, 1'b0, 1'b0);
        foreach (plan[i]) begin
            apply(plan[i]);
            checks++;
            if ({state, outs_w} !== {plan[i].state, plan[i].outs}) begin
                errors++;
                $display("FAIL ldst[%0d]: state=%0d outs=%b, want state=%0d outs=%b",
                         i, state, outs_w, plan[i].state, plan[i].outs);
            end
        end
        plan.delete();
    endtask

    task automatic test_branch_illegal();
        do_reset();
        add(6'b100110, 5'd0, 1'b1, rb(), rb(), rb(), T_IDLE, O_NONE);
        plan_instr(6'b100110, 5'd0, 0, 0, 1'b1, 1'b0);
        plan_instr(6'b100110, 5'd0, 0, 0, 1'b0, 1'b0);
        plan_instr(6'b100100, 5'd0, 0, 0, rb(), 1'b0);
        plan_instr(6'b111111, 5'd0, 0, 0, rb(), 1'b0);
        plan_instr(6'b100000, 5'd0, 0, 0, rb(), 1'b0);
        foreach (plan[i]) begin
            apply(plan[i]);
            checks++;
            if ({state, outs_w} !== {plan[i].state, plan[i].outs}) begin
                errors++;
                $display("FAIL br_ill[%0d]: state=%0d outs=%b, want state=%0d outs=%b",
                         i, state, outs_w, plan[i].state, plan[i].outs);
            end
        end
        plan.delete();
    endtask

    task automatic test_halt();
        do_reset();
        add(6'b100000, 5'd0, 1'b1, rb(), rb(), rb(), T_IDLE, O_NONE);
        plan_instr(6'b100000, 5'd0, 0, 0, 1'b0, 1'b1);
        plan_instr(6'b001010, 5'd0, 0, 1, 1'b0, 1'b1);
        plan_instr(6'b100100, 5'd0, 0, 0, 1'b0, 1'b1);
        plan_instr(6'b100000, 5'd0, 0, 0, 1'b0, 1'b0);
        foreach (plan[i]) begin
            apply(plan[i]);
            checks++;
            if ({state, outs_w} !== {plan[i].state, plan[i].outs}) begin
                errors++;
                $display("FAIL halt[%0d]: state=%0d outs=%b, want state=%0d outs=%b",
                         i, state, outs_w, plan[i].state, plan[i].outs);
            end
        end
        plan.delete();
    endtask

    task automatic test_random();
        logic [5:0] op;
        do_reset();
        add(6'b100000, 5'd0, 1'b1, rb(), rb(), rb(), T_IDLE, O_NONE);
        for (int n = 0; n < 30; n++) begin
            op = ($urandom_range(0, 4) == 0) ? 6'($urandom) : op_pool[$urandom_range(0, 9)];
            plan_instr(op, ($urandom_range(0, 1) == 0) ? 5'b00010 : 5'($urandom),
                       $urandom_range(0, 3), $urandom_range(0, 3), rb(),
                       ($urandom_range(0, 5) == 0));
        end
        foreach (plan[i]) begin
            apply(plan[i]);
            checks++;
            if ({state, outs_w} !== {plan[i].state, plan[i].outs}) begin
                errors++;
                $display("FAIL random[%0d]: op=%b state=%0d outs=%b, want state=%0d outs=%b",
                         i, plan[i].op, state, outs_w, plan[i].state, plan[i].outs);
            end
        end
        plan.delete();
    endtask

    task automatic test_timeout();
        // Fetch never completes: 15 waiting cycles, then sticky ERR
        do_reset();
        add(6'b100000, 5'd0, 1'b1, rb(), rb(), rb(), T_IDLE, O_NONE);
        for (int i = 0; i < 15; i++) add(6'b100000, 5'd0, rb(), 1'b0, rb(), rb(), T_FETCH, O_REQ);
        for (int i = 0; i < 3; i++) add(6'b100000, 5'd0, 1'b1, rb(), rb(), rb(), T_ERR, O_ERR);
        // Data access never completes
        foreach (plan[i]) begin
            apply(plan[i]);
            checks++;
            if ({state, outs_w} !== {plan[i].state, plan[i].outs}) begin
                errors++;
                $display("FAIL fetch_timeout[%0d]: state=%0d outs=%b, want state=%0d outs=%b",
                         i, state, outs_w, plan[i].state, plan[i].outs);
            end
        end
        plan.delete();
        do_reset();
        add(6'b000010, 5'd0, 1'b1, rb(), rb(), rb(), T_IDLE, O_NONE);
        add(6'b000010, 5'd0, rb(), 1'b1, rb(), rb(), T_FETCH, O_REQ | O_IRWE);
        add(6'b000010, 5'd0, rb(), rb(), rb(), rb(), T_DECODE, O_NONE);
        add(6'b000010, 5'd0, rb(), rb(), rb(), rb(), T_EXEC, O_NONE);
        for (int i = 0; i < 15; i++) add(6'b000010, 5'd0, rb(), 1'b0, rb(), rb(), T_MEM, O_REQ | O_ASEL);
        for (int i = 0; i < 2; i++) add(6'b000010, 5'd0, 1'b1, 1'b1, rb(), rb(), T_ERR, O_ERR);
        foreach (plan[i]) begin
            apply(plan[i]);
            checks++;
            if ({state, outs_w} !== {plan[i].state, plan[i].outs}) begin
                errors++;
                $display("FAIL mem_timeout[%0d]: state=%0d outs=%b, want state=%0d outs=%b",
                         i, state, outs_w, plan[i].state, plan[i].outs);
            end
        end
        plan.delete();
    endtask

    task automatic test_reset_mid_mem();
        cyc_t c;
        do_reset();
        add(6'b001010, 5'd0, 1'b1, rb(), rb(), rb(), T_IDLE, O_NONE);
        add(6'b001010, 5'd0, rb(), 1'b1, rb(), rb(), T_FETCH, O_REQ | O_IRWE);
        add(6'b001010, 5'd0, rb(), rb(), rb(), rb(), T_DECODE, O_NONE);
        add(6'b001010, 5'd0, rb(), rb(), rb(), rb(), T_EXEC, O_NONE);
        add(6'b001010, 5'd0, rb(), 1'b0, rb(), rb(), T_MEM, O_REQ | O_ASEL | O_WE);
        add(6'b001010, 5'd0, rb(), 1'b0, rb(), rb(), T_MEM, O_REQ | O_ASEL | O_WE);
        foreach (plan[i]) begin
            apply(plan[i]);
            checks++;
            if ({state, outs_w} !== {plan[i].state, plan[i].outs}) begin
                errors++;
                $display("FAIL pre_rst[%0d]: state=%0d outs=%b, want state=%0d outs=%b",
                         i, state, outs_w, plan[i].state, plan[i].outs);
            end
        end
        plan.delete();
        // Reset lands between clock edges and must act without waiting for one
        #1 rst = 1'b0;
        mem_ready = 1'b1;
        #1;
        checks++;
        if ({state, outs_w} !== {T_IDLE, O_NONE}) begin
            errors++;
            $display("FAIL rst_async: state=%0d outs=%b, want state=0 outs=0", state, outs_w);
        end
        c.op = 6'b001010; c.sub = 5'd0; c.st = 1'b1; c.mr = 1'b1; c.bt = 1'b0; c.hr = 1'b0;
        c.state = T_IDLE; c.outs = O_NONE;
        apply(c);
        checks++;
        if ({state, outs_w} !== {T_IDLE, O_NONE}) begin
            errors++;
            $display("FAIL rst_held: state=%0d outs=%b, want state=0 outs=0", state, outs_w);
        end
        rst = 1'b1;
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    initial begin
        test_reset();
        test_alu();
        test_load_store();
        test_branch_illegal();
        test_halt();
        test_random();
        test_timeout();
        test_reset_mid_mem();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire
